lcd_ctrl: RTL and testbench

// - Downstream consumer of the output-peripheral LCD word (0x7030). Turns software requests into HD44780 bus cycles.
// - Generates setup/enable/execution timing in hardware, so firmware writes one word per LCD command or character.
// - Drives the DE2 LCD pins and returns busy/ack status for the input-peripheral memory.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_ctrl_if.sv | 22 ++
 rtl/lcd_timer.sv | 36 +++
 rtl/lcd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding, LCD word fields and init ROM for lcd_ctrl
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } state_e;

  localparam int TIMER_W      = 20;
  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_REQ_BIT  = 30;
  localparam int LCD_BLON_BIT = 29;
  localparam int LCD_RS_BIT   = 9;

  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    return (idx < 3'(INIT_LEN)) ? INIT_ROM[idx] : 8'h00;
  endfunction

  // Clear display / return home need the long execution wait.
  function automatic logic is_clr_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data != 8'h00) && (data <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - software LCD word plus HD44780 pins and busy/ack status
interface lcd_ctrl_if;
  logic [31:0] lcd_word;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic        lcd_blon;
  logic        busy;
  logic        ack_tgl;

  modport master (
    input  lcd_word,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, ack_tgl
  );

  modport slave (
    output lcd_word,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, ack_tgl
  );
endinterface

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter; done while the count sits at 1
module lcd_timer
  import lcd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_done,
  output logic [TIMER_W-1:0] o_count
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // A zero load would never reach 1, so it is promoted to the shortest interval.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = (i_load_val == '0) ? TIMER_W'(1) : i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done  = (cnt_q == TIMER_W'(1));
  assign o_count = cnt_q;

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 bus-cycle sequencer for the LCD word register
// LCD_CTRL_INIT_EN: power-up wait and hardware init ROM before software requests.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 25,
  parameter int unsigned T_CMD_CYC   = 2500,
  parameter int unsigned T_CLR_CYC   = 82000,
  parameter int unsigned T_PWRUP_CYC = 750000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  lcd_ctrl_if.master   bus
);

  localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(T_SETUP_CYC);
  localparam logic [TIMER_W-1:0] EN_LD    = TIMER_W'(T_EN_CYC);
  localparam logic [TIMER_W-1:0] CMD_LD   = TIMER_W'(T_CMD_CYC);
  localparam logic [TIMER_W-1:0] CLR_LD   = TIMER_W'(T_CLR_CYC);
  localparam logic [TIMER_W-1:0] PWRUP_LD = TIMER_W'(T_PWRUP_CYC);

`ifdef LCD_CTRL_INIT_EN
  localparam state_e RESET_STATE = ST_PWRUP;
  logic [2:0] rom_idx_q, rom_idx_d;
  logic       rom_active_q, rom_active_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e       state_q, state_d;
  logic [7:0]   data_q, data_d;
  logic         rs_q, rs_d;
  logic         en_q, en_d;
  logic         on_q, on_d;
  logic         blon_q, blon_d;
  logic         ack_q, ack_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_done;
  logic               req_pending;

  lcd_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done),
    .o_count    (tmr_count)
  );

  // Level compare: any even number of toggles while busy cancels out.
  assign req_pending = (bus.lcd_word[LCD_REQ_BIT] != ack_q);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = en_q;
    ack_d    = ack_q;
    on_d     = bus.lcd_word[LCD_ON_BIT];
    blon_d   = bus.lcd_word[LCD_BLON_BIT];
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef LCD_CTRL_INIT_EN
    rom_idx_d    = rom_idx_q;
    rom_active_d = rom_active_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        // Timer is zero straight out of reset, so the first cycle arms it.
        if (tmr_count == '0) begin
          tmr_load = 1'b1;
          tmr_val  = PWRUP_LD;
        end else if (tmr_done) begin
`ifdef LCD_CTRL_INIT_EN
          rom_idx_d    = 3'd0;
          rom_active_d = 1'b1;
          rs_d         = 1'b0;
          data_d       = init_byte(3'd0);
          tmr_load     = 1'b1;
          tmr_val      = SETUP_LD;
          state_d      = ST_SETUP;
`else
          state_d      = ST_IDLE;
`endif
        end
      end
      ST_IDLE: begin
        if (req_pending) begin
          rs_d     = bus.lcd_word[LCD_RS_BIT];
          data_d   = bus.lcd_word[7:0];
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        en_d = 1'b0;
        if (tmr_done) begin
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = EN_LD;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = is_clr_cmd(rs_q, data_q) ? CLR_LD : CMD_LD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
`ifdef LCD_CTRL_INIT_EN
          if (rom_active_q && (rom_idx_q != 3'(INIT_LEN - 1))) begin
            rom_idx_d = rom_idx_q + 3'd1;
            rs_d      = 1'b0;
            data_d    = init_byte(rom_idx_q + 3'd1);
            tmr_load  = 1'b1;
            tmr_val   = SETUP_LD;
            state_d   = ST_SETUP;
          end else if (rom_active_q) begin
            rom_active_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            ack_d   = ~ack_q;
            state_d = ST_IDLE;
          end
`else
          ack_d   = ~ack_q;
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= RESET_STATE;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      blon_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef LCD_CTRL_INIT_EN
      rom_idx_q    <= '0;
      rom_active_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= on_d;
      blon_q  <= blon_d;
      ack_q   <= ack_d;
`ifdef LCD_CTRL_INIT_EN
      rom_idx_q    <= rom_idx_d;
      rom_active_q <= rom_active_d;
`endif
    end
  end

  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_on   = on_q;
  assign bus.lcd_blon = blon_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.ack_tgl  = ack_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed vector bench for lcd_ctrl (honours LCD_CTRL_INIT_EN)
module tb_lcd_ctrl;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 3;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 9;
  localparam int T_PWRUP = 20;

`ifdef LCD_CTRL_INIT_EN
  localparam logic BUSY_RST = 1'b1;
  localparam int   INIT_PULSES = 6;
`else
  localparam logic BUSY_RST = 1'b0;
  localparam int   INIT_PULSES = 0;
`endif

  typedef struct {
    logic       on;
    logic       blon;
    logic       rs;
    logic [7:0] data;
    int         wait_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic ack_m = 1'b0;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_SETUP_CYC (T_SETUP),
    .T_EN_CYC    (T_EN),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR),
    .T_PWRUP_CYC (T_PWRUP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // EN pulse monitor: count, data at each rise, EN-low gap preceding each later rise.
  int         en_pulses = 0;
  int         gap_cnt = 0;
  logic       en_prev = 1'b0;
  logic [7:0] cap_data [16];
  int         gaps [16];

  always @(negedge clk) begin
    if (bus.lcd_en && !en_prev) begin
      if (en_pulses < 16) cap_data[en_pulses] = bus.lcd_data;
      if (en_pulses > 0 && en_pulses <= 16) gaps[en_pulses-1] = gap_cnt;
      en_pulses = en_pulses + 1;
    end
    if (!bus.lcd_en && en_prev) gap_cnt = 1;
    else if (!bus.lcd_en) gap_cnt = gap_cnt + 1;
    en_prev = bus.lcd_en;
  end

  function automatic logic [31:0] mk_word(input logic on, input logic req, input logic blon,
                                          input logic rs, input logic [7:0] data);
    return {on, req, blon, 19'b0, rs, 1'b0, data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One software request; word fields other than REQ are scrambled once it is latched.
  task automatic run_txn(input vec_t v, input string tag);
    logic en_tr [40];
    logic busy_tr [40];
    logic stable;
    int   i, s, e, w;
    bus.lcd_word = mk_word(v.on, ~ack_m, v.blon, v.rs, v.data);
    @(negedge clk);
    chk({tag, ".rs"},   bus.lcd_rs, v.rs);
    chk({tag, ".data"}, bus.lcd_data, v.data);
    chk({tag, ".busy"}, bus.busy, 1'b1);
    bus.lcd_word = mk_word(v.on, ~ack_m, v.blon, ~v.rs, ~v.data);
    stable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      en_tr[k]   = bus.lcd_en;
      busy_tr[k] = bus.busy;
      if (bus.busy && (bus.lcd_rs !== v.rs || bus.lcd_data !== v.data)) stable = 1'b0;
      @(negedge clk);
    end
    i = 0; s = 0; e = 0; w = 0;
    while (i < 40 && busy_tr[i] && !en_tr[i]) begin s++; i++; end
    while (i < 40 && en_tr[i]) begin e++; i++; end
    while (i < 40 && busy_tr[i] && !en_tr[i]) begin w++; i++; end
    chk({tag, ".setup"},  s, T_SETUP);
    chk({tag, ".en_w"},   e, T_EN);
    chk({tag, ".wait"},   w, v.wait_cyc);
    chk({tag, ".stable"}, stable, 1'b1);
    chk({tag, ".idle"},   (i < 40) ? busy_tr[i] : 1'b1, 1'b0);
    ack_m = ~ack_m;
    chk({tag, ".ack"},    bus.ack_tgl, ack_m);
  endtask

  vec_t vecs [9];
  int   p0;
  logic [7:0] init_exp [6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h41, T_CMD};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h01, T_CLR};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h02, T_CLR};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h03, T_CLR};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h00, T_CMD};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h04, T_CMD};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h08, T_CMD};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h01, T_CMD};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'hFF, T_CMD};
    init_exp = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    bus.lcd_word = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.en",   bus.lcd_en, 1'b0);
    chk("rst.rs",   bus.lcd_rs, 1'b0);
    chk("rst.data", bus.lcd_data, 8'h00);
    chk("rst.rw",   bus.lcd_rw, 1'b0);
    chk("rst.on",   bus.lcd_on, 1'b0);
    chk("rst.blon", bus.lcd_blon, 1'b0);
    chk("rst.ack",  bus.ack_tgl, 1'b0);
    chk("rst.busy", bus.busy, BUSY_RST);
    rst = 1'b1;

`ifdef LCD_CTRL_INIT_EN
    bus.lcd_word = mk_word(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (en_pulses >= 7 && !bus.busy) break;
    end
    chk("init.pulses", en_pulses, 7);
    for (int k = 0; k < 6; k++) chk($sformatf("init.rom%0d", k), cap_data[k], init_exp[k]);
    chk("init.clr_wait", gaps[4] - T_SETUP, T_CLR);
    chk("init.req_data", cap_data[6], 8'h5A);
    chk("init.ack", bus.ack_tgl, 1'b1);
    ack_m = 1'b1;
`endif

    // Latency from applying a request to ack, with EN placement.
    bus.lcd_word = mk_word(1'b1, ~ack_m, 1'b0, 1'b1, 8'h41);
    @(negedge clk);
    chk("lat.rs", bus.lcd_rs, 1'b1);
    chk("lat.data", bus.lcd_data, 8'h41);
    chk("lat.busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("lat.en_lo", bus.lcd_en, 1'b0);
    @(negedge clk);
    chk("lat.en_rise", bus.lcd_en, 1'b1);
    repeat (2) @(negedge clk);
    chk("lat.en_last", bus.lcd_en, 1'b1);
    @(negedge clk);
    chk("lat.en_fall", bus.lcd_en, 1'b0);
    chk("lat.ack_wait", bus.ack_tgl, ack_m);
    repeat (5) @(negedge clk);
    ack_m = ~ack_m;
    chk("lat.ack", bus.ack_tgl, ack_m);
    chk("lat.idle", bus.busy, 1'b0);

    for (int k = 0; k < 9; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // Two REQ toggles while busy cancel out.
    p0 = en_pulses;
    bus.lcd_word = mk_word(1'b1, ~ack_m, 1'b0, 1'b1, 8'h55);
    repeat (3) @(negedge clk);
    bus.lcd_word[30] = ~bus.lcd_word[30];
    @(negedge clk);
    bus.lcd_word[30] = ~bus.lcd_word[30];
    repeat (40) @(negedge clk);
    ack_m = ~ack_m;
    chk("col2.pulses", en_pulses - p0, 1);
    chk("col2.ack", bus.ack_tgl, ack_m);
    chk("col2.idle", bus.busy, 1'b0);

    // Three toggles leave one more request behind.
    p0 = en_pulses;
    bus.lcd_word = mk_word(1'b1, ~ack_m, 1'b0, 1'b1, 8'h66);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.lcd_word[30] = ~bus.lcd_word[30];
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    chk("col3.pulses", en_pulses - p0, 2);
    chk("col3.ack", bus.ack_tgl, ack_m);
    chk("col3.idle", bus.busy, 1'b0);

    // ON/BLON follow the word while a transaction runs.
    p0 = en_pulses;
    bus.lcd_word = mk_word(1'b0, ~ack_m, 1'b0, 1'b0, 8'h08);
    repeat (2) @(negedge clk);
    chk("onb.on0", bus.lcd_on, 1'b0);
    chk("onb.blon0", bus.lcd_blon, 1'b0);
    bus.lcd_word[31] = 1'b1;
    bus.lcd_word[29] = 1'b1;
    @(negedge clk);
    chk("onb.on1", bus.lcd_on, 1'b1);
    chk("onb.blon1", bus.lcd_blon, 1'b1);
    bus.lcd_word[31] = 1'b0;
    @(negedge clk);
    chk("onb.on2", bus.lcd_on, 1'b0);
    chk("onb.blon2", bus.lcd_blon, 1'b1);
    chk("onb.busy", bus.busy, 1'b1);
    repeat (20) @(negedge clk);
    ack_m = ~ack_m;
    chk("onb.pulses", en_pulses - p0, 1);
    chk("onb.data", cap_data[p0], 8'h08);
    chk("onb.ack", bus.ack_tgl, ack_m);

    // Reset during the EN pulse drops everything without an ack.
    bus.lcd_word = mk_word(1'b1, ~ack_m, 1'b1, 1'b1, 8'h33);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.lcd_en) break;
    end
    chk("midrst.en_seen", bus.lcd_en, 1'b1);
    rst = 1'b0;
    bus.lcd_word = 32'h0;
    @(negedge clk);
    chk("midrst.en", bus.lcd_en, 1'b0);
    chk("midrst.busy", bus.busy, BUSY_RST);
    chk("midrst.ack", bus.ack_tgl, 1'b0);
    rst = 1'b1;
    ack_m = 1'b0;
    p0 = en_pulses;
    repeat (150) @(negedge clk);
    chk("midrst.pulses", en_pulses - p0, INIT_PULSES);
    chk("midrst.ack_after", bus.ack_tgl, 1'b0);
    chk("midrst.idle", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
